// File: rtl/ip_tx_arbiter_if.sv
// Request-side handshake and ip_packet_tx-side signals of ip_tx_arbiter, bundled as one interface.
// slave is the arbiter's view; master is the view of the requesters plus the transmit engine.
interface ip_tx_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]    REQ_VALID;
    logic [NUM_REQ-1:0]    REQ_READY;
    logic [32*NUM_REQ-1:0] REQ_IP_ADDRESS;
    logic [48*NUM_REQ-1:0] REQ_MAC_ADDRESS;
    logic [10*NUM_REQ-1:0] REQ_MESSAGE;
    logic [31:0]           TX_RECIPIENT_IP;
    logic [47:0]           TX_RECIPIENT_MAC;
    logic [9:0]            TX_MESSAGE;
    logic                  TX_START;
    logic                  TX_READY_FOR_SEND;
    logic                  DONE_VALID;
    logic [GRANT_W-1:0]    DONE_ID;
    logic                  BUSY;
    logic [1:0]            dbg_state;

    // Handshake: requester i transfers on a rising edge where REQ_VALID[i] and REQ_READY[i]
    // are both high; REQ_READY[i] comes from registered state only, and REQ_VALID[i] plus
    // its address/message fields must stay stable while waiting for REQ_READY[i].
    modport slave (
        input  REQ_VALID, REQ_IP_ADDRESS, REQ_MAC_ADDRESS, REQ_MESSAGE, TX_READY_FOR_SEND,
        output REQ_READY, TX_RECIPIENT_IP, TX_RECIPIENT_MAC, TX_MESSAGE, TX_START,
        output DONE_VALID, DONE_ID, BUSY, dbg_state
    );

    modport master (
        output REQ_VALID, REQ_IP_ADDRESS, REQ_MAC_ADDRESS, REQ_MESSAGE, TX_READY_FOR_SEND,
        input  REQ_READY, TX_RECIPIENT_IP, TX_RECIPIENT_MAC, TX_MESSAGE, TX_START,
        input  DONE_VALID, DONE_ID, BUSY, dbg_state
    );
endinterface

// File: rtl/ip_tx_arbiter.sv
// Round-robin arbiter sharing one ip_packet_tx engine between NUM_REQ requesters,
// each with a one-entry holding slot; packets are sent strictly one at a time.
module ip_tx_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic          ACLK,
    input  logic          ARESET,
    ip_tx_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_e;

    localparam logic [GRANT_W-1:0] LAST_RST = GRANT_W'(NUM_REQ - 1);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   pending_q, pending_d, fire;
    logic [31:0]          slot_ip_q  [NUM_REQ];
    logic [47:0]          slot_mac_q [NUM_REQ];
    logic [9:0]           slot_msg_q [NUM_REQ];
    logic [GRANT_W-1:0]   grant_q, grant_d, last_grant_q, last_grant_d;
    logic [31:0]          tx_ip_q, tx_ip_d;
    logic [47:0]          tx_mac_q, tx_mac_d;
    logic [9:0]           tx_msg_q, tx_msg_d;
    logic                 tx_start_q, tx_start_d;
    logic                 done_valid_q, done_valid_d;
    logic [GRANT_W-1:0]   done_id_q, done_id_d;
    logic                 busy_q, busy_d;
    logic                 pick_found, grant_go;
    logic [GRANT_W-1:0]   pick_idx, cand;

    assign fire = bus.REQ_VALID & ~pending_q;

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_ip_q[i]  <= '0;
                slot_mac_q[i] <= '0;
                slot_msg_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (fire[i]) begin
                    slot_ip_q[i]  <= bus.REQ_IP_ADDRESS[32*i +: 32];
                    slot_mac_q[i] <= bus.REQ_MAC_ADDRESS[48*i +: 48];
                    slot_msg_q[i] <= bus.REQ_MESSAGE[10*i +: 10];
                end
            end
        end
    end

    // The served slot frees in the DONE cycle, so REQ_READY rises the cycle after DONE.
    always_comb begin
        pending_d = pending_q | fire;
        if (done_valid_q) pending_d[done_id_q] = 1'b0;
    end

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GRANT_W'((int'(last_grant_q) + k) % NUM_REQ);
            if (!pick_found && pending_q[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Holding off during the DONE cycle keeps the finished slot from being re-granted.
    assign grant_go = (state_q == ST_IDLE) && pick_found && bus.TX_READY_FOR_SEND && !done_valid_q;

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (grant_go) state_d = ST_START;
            ST_START:     state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (!bus.TX_READY_FOR_SEND) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (bus.TX_READY_FOR_SEND) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_ip_d      = tx_ip_q;
        tx_mac_d     = tx_mac_q;
        tx_msg_d     = tx_msg_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        tx_start_d   = 1'b0;
        done_valid_d = 1'b0;
        done_id_d    = done_id_q;
        busy_d       = (state_d != ST_IDLE);
        if (grant_go) begin
            tx_ip_d      = slot_ip_q[pick_idx];
            tx_mac_d     = slot_mac_q[pick_idx];
            tx_msg_d     = slot_msg_q[pick_idx];
            grant_d      = pick_idx;
            last_grant_d = pick_idx;
            tx_start_d   = 1'b1;
        end
        if ((state_q == ST_WAIT_DONE) && bus.TX_READY_FOR_SEND) begin
            done_valid_d = 1'b1;
            done_id_d    = grant_q;
        end
    end

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            pending_q    <= '0;
            grant_q      <= '0;
            last_grant_q <= LAST_RST;
            tx_ip_q      <= '0;
            tx_mac_q     <= '0;
            tx_msg_q     <= '0;
            tx_start_q   <= 1'b0;
            done_valid_q <= 1'b0;
            done_id_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            tx_ip_q      <= tx_ip_d;
            tx_mac_q     <= tx_mac_d;
            tx_msg_q     <= tx_msg_d;
            tx_start_q   <= tx_start_d;
            done_valid_q <= done_valid_d;
            done_id_q    <= done_id_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.REQ_READY        = ~pending_q;
    assign bus.TX_RECIPIENT_IP  = tx_ip_q;
    assign bus.TX_RECIPIENT_MAC = tx_mac_q;
    assign bus.TX_MESSAGE       = tx_msg_q;
    assign bus.TX_START         = tx_start_q;
    assign bus.DONE_VALID       = done_valid_q;
    assign bus.DONE_ID          = done_id_q;
    assign bus.BUSY             = busy_q;
    assign bus.dbg_state        = state_q;
endmodule
